sm_alu_seq: RTL

Parametrised sign-magnitude ALU, successor to the team's combinational 4-bit sign-magnitude adder. Operands and result are sign-magnitude: a WIDTH-bit magnitude plus a separate sign bit.
- Adds four operations: add, subtract, negate, and a multi-cycle shift-add multiply.
- Adds an overflow flag, negative-zero normalisation and a start/busy/done handshake.
- Sits between operand registers (switch/keypad front end) and the display/result register path.

---
 rtl/sm_alu_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sm_alu_seq.sv
// Sign-magnitude ALU: add/sub/neg in one cycle, shift-add multiply in WIDTH cycles.
// Operands are latched on an accepted start; the result is held until the next done.
//
// state | meaning
// IDLE  | waiting for start; result outputs held
// ALU   | single-cycle add/sub/neg on latched operands
// MUL   | one shift-add step per cycle over B, LSB first
module sm_alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_mag,
    input  logic             a_sign,
    input  logic [WIDTH-1:0] b_mag,
    input  logic             b_sign,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c_mag,
    output logic             c_sign,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ALU, MUL} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_r, b_r;
    logic               a_s_r, b_s_r;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic               a_s_in, b_s_in;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_mag;
    logic               alu_sign, alu_ovf;
    logic [2*WIDTH-1:0] partial, prod_next;
    logic [WIDTH-1:0]   mul_mag;
    logic               mul_sign, mul_ovf;

    // A zero magnitude never carries a negative sign into the datapath.
    assign a_s_in = a_sign & (|a_mag);
    assign b_s_in = b_sign & (|b_mag);

    always_comb begin
        sum      = {1'b0, a_r} + {1'b0, b_r};
        alu_mag  = '0;
        alu_sign = 1'b0;
        alu_ovf  = 1'b0;
        if (a_s_r == b_s_r) begin
            alu_mag  = sum[WIDTH-1:0];
            alu_ovf  = sum[WIDTH];
            alu_sign = a_s_r;
        end else if (a_r >= b_r) begin
            alu_mag  = a_r - b_r;
            alu_sign = a_s_r;
        end else begin
            alu_mag  = b_r - a_r;
            alu_sign = b_s_r;
        end
        if (!alu_ovf && alu_mag == '0) alu_sign = 1'b0;
    end

    always_comb begin
        partial   = b_r[cnt] ? ({{WIDTH{1'b0}}, a_r} << cnt) : '0;
        prod_next = acc + partial;
        mul_mag   = prod_next[WIDTH-1:0];
        mul_ovf   = |prod_next[2*WIDTH-1:WIDTH];
        // A wrapped-to-zero overflowing product still reports its true sign.
        mul_sign  = (a_s_r ^ b_s_r) & (mul_ovf | (|mul_mag));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            a_s_r  <= 1'b0;
            b_s_r  <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            c_mag  <= '0;
            c_sign <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        a_r   <= a_mag;
                        a_s_r <= a_s_in;
                        b_r   <= b_mag;
                        b_s_r <= b_s_in;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ALU;
                        case (op)
                            2'b01: b_s_r <= ~b_s_in;
                            2'b10: state <= MUL;
                            2'b11: begin
                                a_s_r <= ~a_s_in;
                                b_r   <= '0;
                                b_s_r <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ALU: begin
                    c_mag  <= alu_mag;
                    c_sign <= alu_sign;
                    ovf    <= alu_ovf;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                MUL: begin
                    acc <= prod_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        c_mag  <= mul_mag;
                        c_sign <= mul_sign;
                        ovf    <= mul_ovf;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
